// File: rtl/ball_collision_detector.sv
// Per-frame overlap counter between camera object mask and ball box; pulse one cycle after frame-end pixel, ball_pixel 1 cycle.
// Free-running pixel stream, no backpressure: every DE pixel is consumed the cycle it arrives.
module ball_collision_detector #(
    parameter int BALL_SIZE       = 20,
    parameter int HIT_THRESHOLD   = 16,
    parameter int COOLDOWN_FRAMES = 8
) (
    input  logic        clk_25MHZ,
    input  logic        reset,
    input  logic        upscale,
    input  logic        DE,
    input  logic [9:0]  x_pixel,
    input  logic [9:0]  y_pixel,
    input  logic        obj_mask,
    input  logic [9:0]  ball_x,
    input  logic [9:0]  ball_y,
    output logic        collision_detected,
    output logic [11:0] overlap_count,
    output logic        ball_pixel
);

    localparam logic [10:0] BOX_EXT = 11'(BALL_SIZE - 1);
    localparam logic [11:0] ACC_MAX = 12'hFFF;
    localparam logic [11:0] THRESH  = 12'(HIT_THRESHOLD);
    localparam logic [3:0]  CD_INIT = 4'(COOLDOWN_FRAMES);

    typedef enum logic [1:0] {
        SYNC     = 2'd0,
        SCAN     = 2'd1,
        COOLDOWN = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [9:0]  r_ball_x_sh;
    logic [9:0]  r_ball_y_sh;
    logic [11:0] r_acc;
    logic [3:0]  r_cooldown;
    logic        r_collision;
    logic [11:0] r_overlap_count;
    logic        r_ball_pixel;

    logic [9:0]  w_x_max;
    logic [9:0]  w_y_max;
    logic        w_frame_start;
    logic        w_frame_end;
    logic [9:0]  w_box_x;
    logic [9:0]  w_box_y;
    logic        w_in_x;
    logic        w_in_y;
    logic        w_in_box;
    logic        w_hit;
    logic [11:0] w_acc_final;
    logic        w_over_th;
    logic        w_eval;
    logic        w_pulse_set;
    logic        w_cd_dec;

    // Frame boundaries follow the live upscale input, so a mid-frame change takes effect at once.
    assign w_x_max       = upscale ? 10'd639 : 10'd319;
    assign w_y_max       = upscale ? 10'd479 : 10'd239;
    assign w_frame_start = DE && (x_pixel == 10'd0) && (y_pixel == 10'd0);
    assign w_frame_end   = DE && (x_pixel == w_x_max) && (y_pixel == w_y_max);

    // The frame-start pixel must already see the freshly sampled ball position.
    assign w_box_x = w_frame_start ? ball_x : r_ball_x_sh;
    assign w_box_y = w_frame_start ? ball_y : r_ball_y_sh;

    assign w_in_x = ({1'b0, x_pixel} >= {1'b0, w_box_x}) &&
                    ({1'b0, x_pixel} <= ({1'b0, w_box_x} + BOX_EXT));
    assign w_in_y = ({1'b0, y_pixel} >= {1'b0, w_box_y}) &&
                    ({1'b0, y_pixel} <= ({1'b0, w_box_y} + BOX_EXT));
    assign w_in_box = w_in_x && w_in_y;
    assign w_hit    = DE && obj_mask && w_in_box;

    assign w_acc_final = (w_hit && (r_acc != ACC_MAX)) ? (r_acc + 12'd1) : r_acc;
    assign w_over_th   = (w_acc_final >= THRESH);

    always_ff @(posedge clk_25MHZ or posedge reset) begin
        if (reset) begin
            r_state <= SYNC;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            SYNC: begin
                if (w_frame_start) begin
                    w_state_next = SCAN;
                end
            end
            SCAN: begin
                if (w_eval && w_over_th) begin
                    w_state_next = COOLDOWN;
                end
            end
            COOLDOWN: begin
                if (w_eval && (r_cooldown <= 4'd1)) begin
                    w_state_next = SCAN;
                end
            end
            default: begin
                w_state_next = SYNC;
            end
        endcase
    end

    always_comb begin
        w_eval      = 1'b0;
        w_pulse_set = 1'b0;
        w_cd_dec    = 1'b0;
        case (r_state)
            SCAN: begin
                w_eval      = w_frame_end && !w_frame_start;
                w_pulse_set = w_eval && w_over_th;
            end
            COOLDOWN: begin
                w_eval   = w_frame_end && !w_frame_start;
                w_cd_dec = w_eval;
            end
            default: begin
                w_eval = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_25MHZ or posedge reset) begin
        if (reset) begin
            r_ball_x_sh <= 10'd0;
            r_ball_y_sh <= 10'd0;
        end else if (w_frame_start) begin
            r_ball_x_sh <= ball_x;
            r_ball_y_sh <= ball_y;
        end
    end

    // A frame start always restarts the count, including a glitched one mid-frame.
    always_ff @(posedge clk_25MHZ or posedge reset) begin
        if (reset) begin
            r_acc <= 12'd0;
        end else if (w_frame_start) begin
            r_acc <= {11'd0, w_hit};
        end else if ((r_state == SYNC) || w_frame_end) begin
            r_acc <= 12'd0;
        end else begin
            r_acc <= w_acc_final;
        end
    end

    always_ff @(posedge clk_25MHZ or posedge reset) begin
        if (reset) begin
            r_overlap_count <= 12'd0;
            r_collision     <= 1'b0;
            r_cooldown      <= 4'd0;
        end else begin
            r_collision <= w_pulse_set;
            if (w_eval) begin
                r_overlap_count <= w_acc_final;
            end
            if (w_pulse_set) begin
                r_cooldown <= CD_INIT;
            end else if (w_cd_dec && (r_cooldown != 4'd0)) begin
                r_cooldown <= r_cooldown - 4'd1;
            end
        end
    end

    always_ff @(posedge clk_25MHZ or posedge reset) begin
        if (reset) begin
            r_ball_pixel <= 1'b0;
        end else begin
            r_ball_pixel <= DE && w_in_box;
        end
    end

    assign collision_detected = r_collision;
    assign overlap_count      = r_overlap_count;
    assign ball_pixel         = r_ball_pixel;

endmodule

// File: tb/tb_ball_collision_detector.sv
// Directed bench for ball_collision_detector using sparse frames: only the pixels that matter are driven with DE=1.
module tb_ball_collision_detector;

    typedef struct {
        int x0;
        int y0;
        int x1;
        int y1;
    } rect_t;

    typedef struct {
        bit    up;
        int    bx;
        int    by;
        rect_t scan1;
        rect_t scan2;
        rect_t mask;
        int    exp_cnt;
        bit    exp_pulse;
    } vec_t;

    logic        clk_25MHZ = 1'b0;
    logic        reset     = 1'b1;
    logic        upscale   = 1'b0;
    logic        DE        = 1'b0;
    logic [9:0]  x_pixel   = '0;
    logic [9:0]  y_pixel   = '0;
    logic        obj_mask  = 1'b0;
    logic [9:0]  ball_x    = '0;
    logic [9:0]  ball_y    = '0;
    logic        collision_detected;
    logic [11:0] overlap_count;
    logic        ball_pixel;

    int checks     = 0;
    int failures   = 0;
    int mid_pulses = 0;

    ball_collision_detector dut (
        .clk_25MHZ          (clk_25MHZ),
        .reset              (reset),
        .upscale            (upscale),
        .DE                 (DE),
        .x_pixel            (x_pixel),
        .y_pixel            (y_pixel),
        .obj_mask           (obj_mask),
        .ball_x             (ball_x),
        .ball_y             (ball_y),
        .collision_detected (collision_detected),
        .overlap_count      (overlap_count),
        .ball_pixel         (ball_pixel)
    );

    always #20 clk_25MHZ = ~clk_25MHZ;

    function automatic void check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    function automatic bit in_rect(input int x, input int y, input rect_t r);
        return (x >= r.x0) && (x <= r.x1) && (y >= r.y0) && (y <= r.y1);
    endfunction

    // Inputs change 1ns after an edge; outputs are read 1ns after the edge that consumed them.
    task automatic step(input bit de, input int x, input int y, input bit m);
        DE       = de;
        x_pixel  = 10'(x);
        y_pixel  = 10'(y);
        obj_mask = m;
        @(posedge clk_25MHZ);
        #1;
    endtask

    task automatic apply_reset();
        DE       = 1'b0;
        obj_mask = 1'b0;
        reset    = 1'b1;
        @(posedge clk_25MHZ);
        #1;
        check("reset_pulse", int'(collision_detected), 0);
        check("reset_count", int'(overlap_count), 0);
        check("reset_ball_pixel", int'(ball_pixel), 0);
        @(negedge clk_25MHZ);
        reset = 1'b0;
    endtask

    task automatic start_frame(input rect_t m);
        step(1'b1, 0, 0, in_rect(0, 0, m));
        if (collision_detected) mid_pulses++;
    endtask

    task automatic scan_rect(input rect_t r, input rect_t m, input int xmax, input int ymax);
        for (int y = r.y0; y <= r.y1; y++) begin
            for (int x = r.x0; x <= r.x1; x++) begin
                if (x > xmax || y > ymax) continue;
                if ((x == 0 && y == 0) || (x == xmax && y == ymax)) continue;
                step(1'b1, x, y, in_rect(x, y, m));
                if (collision_detected) mid_pulses++;
            end
        end
    endtask

    task automatic end_frame(input rect_t m, input int xmax, input int ymax,
                             output bit p_end, output bit p_after);
        step(1'b1, xmax, ymax, in_rect(xmax, ymax, m));
        p_end = collision_detected;
        step(1'b0, 0, 0, 1'b0);
        p_after = collision_detected;
    endtask

    task automatic full_frame(input rect_t s1, input rect_t s2, input rect_t m, input int xmax,
                              input int ymax, input int exp_cnt, input bit exp_pulse,
                              input string tag);
        bit pe;
        bit pa;
        mid_pulses = 0;
        start_frame(m);
        scan_rect(s1, m, xmax, ymax);
        scan_rect(s2, m, xmax, ymax);
        end_frame(m, xmax, ymax, pe, pa);
        check({tag, "_count"}, int'(overlap_count), exp_cnt);
        check({tag, "_pulse"}, int'(pe), int'(exp_pulse));
        check({tag, "_pulse_drop"}, int'(pa), 0);
        check({tag, "_mid_pulses"}, mid_pulses, 0);
    endtask

    vec_t  vecs[5];
    rect_t none;
    rect_t box100;

    initial begin
        bit pe;
        bit pa;
        int xmax;
        int ymax;

        none   = '{1, 1, 0, 0};
        box100 = '{100, 80, 119, 99};
        vecs[0] = '{1'b0, 100, 80, '{100, 80, 119, 99}, '{1, 1, 0, 0}, '{100, 80, 103, 83}, 16, 1'b1};
        vecs[1] = '{1'b0, 100, 80, '{100, 80, 119, 99}, '{1, 1, 0, 0}, '{100, 80, 104, 82}, 15, 1'b0};
        vecs[2] = '{1'b0, 310, 230, '{300, 220, 319, 239}, '{0, 230, 9, 239}, '{0, 0, 639, 479}, 100, 1'b1};
        vecs[3] = '{1'b1, 600, 440, '{600, 440, 619, 459}, '{319, 239, 319, 239}, '{600, 440, 603, 443}, 16, 1'b1};
        vecs[4] = '{1'b0, 0, 0, '{0, 0, 19, 19}, '{1, 1, 0, 0}, '{0, 0, 19, 19}, 400, 1'b1};

        for (int i = 0; i < 5; i++) begin
            apply_reset();
            upscale = vecs[i].up;
            ball_x  = 10'(vecs[i].bx);
            ball_y  = 10'(vecs[i].by);
            xmax    = vecs[i].up ? 639 : 319;
            ymax    = vecs[i].up ? 479 : 239;
            full_frame(vecs[i].scan1, vecs[i].scan2, vecs[i].mask, xmax, ymax,
                       vecs[i].exp_cnt, vecs[i].exp_pulse, $sformatf("vec%0d", i));
        end

        // Reset lands mid-frame: the tail of that frame must not be evaluated.
        upscale = 1'b0;
        ball_x  = 10'd100;
        ball_y  = 10'd80;
        apply_reset();
        start_frame('{100, 80, 103, 83});
        scan_rect('{100, 80, 119, 81}, '{100, 80, 103, 83}, 319, 239);
        apply_reset();
        mid_pulses = 0;
        scan_rect('{100, 82, 119, 99}, '{100, 80, 103, 83}, 319, 239);
        end_frame('{100, 80, 103, 83}, 319, 239, pe, pa);
        check("partial_pulse", int'(pe), 0);
        check("partial_count", int'(overlap_count), 0);
        check("partial_mid_pulses", mid_pulses, 0);
        full_frame(box100, none, '{100, 80, 103, 83}, 319, 239, 16, 1'b1, "after_partial");

        // A sub-threshold frame leaves the detector armed for the next one.
        apply_reset();
        full_frame(box100, none, '{100, 80, 104, 82}, 319, 239, 15, 1'b0, "below_th");
        full_frame(box100, none, '{100, 80, 103, 83}, 319, 239, 16, 1'b1, "rearmed");

        // Cooldown: hit on frame 0, silent frames 1..8, next pulse at frame 9.
        apply_reset();
        for (int f = 0; f < 10; f++) begin
            full_frame(box100, none, box100, 319, 239, 400, (f == 0) || (f == 9),
                       $sformatf("cool_f%0d", f));
        end

        // Ball moves mid-frame: the box sampled at frame start stays in force.
        apply_reset();
        ball_x = 10'd100;
        ball_y = 10'd80;
        mid_pulses = 0;
        start_frame(none);
        for (int x = 90; x <= 130; x++) begin
            if (x == 110) ball_x = 10'd50;
            step(1'b1, x, 85, x >= 95);
            check($sformatf("move_ball_pixel_x%0d", x), int'(ball_pixel),
                  int'((x >= 100) && (x <= 119)));
            if (collision_detected) mid_pulses++;
        end
        step(1'b0, 105, 85, 1'b1);
        check("de_low_ball_pixel", int'(ball_pixel), 0);
        end_frame('{95, 85, 130, 85}, 319, 239, pe, pa);
        check("move_count", int'(overlap_count), 20);
        check("move_pulse", int'(pe), 1);
        check("move_pulse_drop", int'(pa), 0);
        check("move_mid_pulses", mid_pulses, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ball_collision_detector.md
Name: ball_collision_detector

Overview:
- Sits directly upstream of the ball game controller and drives its collision_detected input.
- Each frame, counts active pixels where the camera object mask overlaps the 20x20 ball box at the current ball position.
- At end of frame, issues a one-cycle collision pulse if the count reaches a threshold, then holds off further pulses for a cooldown.
- Also provides a registered ball-box overlay flag for the downstream pixel mixer.

Parameters:
- BALL_SIZE, 20, ball box edge length in pixels.
- HIT_THRESHOLD, 16, minimum overlap pixels per frame for a hit.
- COOLDOWN_FRAMES, 8, number of full frames after a hit during which no pulse is issued (1..15).

Ports:
- clk_25MHZ  input  1  pixel clock.
- reset  input  1  asynchronous, active-high.
- upscale  input  1  0 = 320x240 game space; 1 = 640x480.
- DE  input  1  active-video qualifier for x_pixel/y_pixel/obj_mask.
- x_pixel  input  10  current pixel column in game space.
- y_pixel  input  10  current pixel row in game space.
- obj_mask  input  1  1 = camera colour filter marks this pixel as paddle/object.
- ball_x  input  10  ball box left edge (from game controller).
- ball_y  input  10  ball box top edge.
- collision_detected  output  1  one-cycle hit pulse.
- overlap_count  output  12  overlap count of the last completed frame.
- ball_pixel  output  1  registered: previous-cycle pixel lies inside the ball box.

Behaviour:
- Reset is asynchronous, active-high; clock is clk_25MHZ.
- Reset values: collision_detected=0, overlap_count=0, ball_pixel=0, internal accumulator=0, cooldown=0, state=SYNC.
- Frame limits: X_MAX=upscale?639:319, Y_MAX=upscale?479:239.
  - Frame start: DE=1 and x_pixel=0 and y_pixel=0.
  - Frame end: DE=1 and x_pixel=X_MAX and y_pixel=Y_MAX.
- In-box test uses 11-bit unsigned arithmetic: ball_x<=x_pixel<=ball_x+BALL_SIZE-1, and the same form for y. No wrap; a box extending past the screen edge is simply clipped.
- ball_x/ball_y are sampled into shadow registers at frame start and used for the whole frame. This prevents a mid-frame move from tearing the box.
- ball_pixel = registered (DE and in-box) using the shadow registers; 1-cycle latency.
- Hit pixel: DE and obj_mask and in-box. The accumulator increments by 1 per hit pixel and saturates at 4095.
- State SYNC:
  - Accumulator held at 0.
  - On frame start, go to SCAN; the frame-start pixel itself is counted.
  - A partial frame after reset is never evaluated.
- State SCAN:
  - Accumulate hit pixels.
  - At frame end, include that pixel's hit, then on the next edge:
    - overlap_count <= final count and accumulator <= 0.
    - If final count >= HIT_THRESHOLD: collision_detected=1 for exactly one cycle, cooldown <= COOLDOWN_FRAMES, go to COOLDOWN.
    - Otherwise stay in SCAN.
- State COOLDOWN:
  - Accumulation and overlap_count update continue exactly as in SCAN, but no pulse is issued.
  - Each frame end decrements cooldown. When cooldown reaches 0, go to SCAN, so the frame ending at that decrement is not evaluated.
  - Net effect: the earliest next pulse is at the end of frame COOLDOWN_FRAMES+1 after the hit frame.
- Frame start while already mid-frame (timing glitch): accumulator restarts at the frame-start pixel's value; no evaluation.
- Frame start and frame end in the same cycle cannot occur (X_MAX>0).
- upscale changing mid-frame: the new limits apply immediately. If this makes the frame-end condition unreachable, the frame is simply never evaluated until the next frame end.
- DE=0 cycles: no counting; ball_pixel=0 on the next cycle.
- Pulse latency: collision_detected asserts on the cycle after the frame-end pixel and is high for exactly 1 clock.

Test Plan:
- Reset mid-frame, then a full 320x240 frame (upscale=0) with ball (100,80) and obj_mask=1 over x 100..103, y 80..83 (16 pixels). Expect: no pulse for the partial frame; the full frame yields overlap_count=16 and a single 1-cycle pulse the cycle after pixel (319,239).
- Same setup with the mask covering 15 pixels. Expect: overlap_count=15, no pulse, state stays SCAN.
- Hit on frame 0, then the 400-pixel full-box mask held for 10 frames. Expect: frame 0 pulse; frames 1..8 overlap_count=400 with no pulse; next pulse at end of frame 9.
- Ball at (310,230) with upscale=0 and mask everywhere. Expect: clipped box counts 10x10=100, no wrap to x=0; pulse.
- Change ball_x from 100 to 50 mid-frame. Expect: the count uses the box at 100 for the whole frame; ball_pixel is high exactly at x 100..119 one cycle late.
- upscale=1 with ball (600,440). Expect: the frame end is detected at (639,479), not (319,239); count and pulse behave as in the first scenario.
